// File: rtl/mvm_pkg.sv
// Shared types and default sizes for the MVM host driver.
//   cmd_op_e : host command encoding
//   state_e  : driver FSM state encoding
//   K/P/B_DEF: default MVM rows, columns and operand width
package mvm_pkg;

  localparam int unsigned K_DEF = 8;
  localparam int unsigned P_DEF = 8;
  localparam int unsigned B_DEF = 20;

  typedef enum logic [1:0] {
    OP_LOAD_MATRIX = 2'd0,
    OP_LOAD_VECTOR = 2'd1,
    OP_RUN         = 2'd2,
    OP_RESERVED    = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_ARM       = 3'd2,
    ST_BURST     = 3'd3,
    ST_GAP       = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_CAPTURE   = 3'd6,
    ST_DRAIN     = 3'd7
  } state_e;

endpackage

// File: rtl/mvm_host_driver_if.sv
// Host-side bus of the MVM host driver.
//   cmd_*  : command handshake (valid/ready + op)
//   in_*   : operand word stream into the driver
//   res_*  : 2B-bit signed result stream out of the driver
//   busy, timeout_err : status
// master = host side, slave = driver side.
interface mvm_host_driver_if
  import mvm_pkg::*;
#(
  parameter int unsigned B = B_DEF
);

  logic           cmd_valid;
  logic           cmd_ready;
  cmd_op_e        cmd_op;
  logic           in_valid;
  logic           in_ready;
  logic [B-1:0]   in_data;
  logic           res_valid;
  logic           res_ready;
  logic [2*B-1:0] res_data;
  logic           busy;
  logic           timeout_err;

  modport master (
    output cmd_valid, cmd_op, in_valid, in_data, res_ready,
    input  cmd_ready, in_ready, res_valid, res_data, busy, timeout_err
  );

  modport slave (
    input  cmd_valid, cmd_op, in_valid, in_data, res_ready,
    output cmd_ready, in_ready, res_valid, res_data, busy, timeout_err
  );

endinterface

// File: rtl/mvm_host_driver_mem.sv
// Staging buffer: simple dual-port RAM, one write and one read port.
//   clk, reset      : clock, async active-low reset (read register only)
//   wr_en/addr/data : synchronous write
//   rd_en/addr      : synchronous read request
//   rd_data         : read word one cycle after rd_en; zero when no read was issued
module mvm_host_driver_mem #(
  parameter int unsigned W     = 20,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Array write; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register returns zero on idle cycles so it can drive a bus directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/mvm_host_driver.sv
// Host driver for a K x P matrix-vector multiplier.
// Stages matrix/vector words from the host, replays them to the MVM as a
// gapless burst behind a one-cycle load strobe, starts runs, captures the K
// results a fixed offset after mvm_done, and streams them back to the host.
//   clk, reset         : clock, async active-low reset
//   host               : host bus (slave modport)
//   mvm_loadMatrix/... : one-cycle strobes to the MVM
//   mvm_data           : operand bus to the MVM, zero outside BURST
//   mvm_done           : MVM completion pulse
//   mvm_result         : MVM result bus, sampled RES_OFFSET cycles after done
// RES_OFFSET must be >= 1 and TIMEOUT >= 1.
module mvm_host_driver
  import mvm_pkg::*;
#(
  parameter int unsigned K          = K_DEF,
  parameter int unsigned P          = P_DEF,
  parameter int unsigned B          = B_DEF,
  parameter int unsigned RES_OFFSET = 2,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             reset,
  mvm_host_driver_if.slave host,
  output logic             mvm_loadMatrix,
  output logic             mvm_loadVector,
  output logic             mvm_start,
  output logic [B-1:0]     mvm_data,
  input  logic             mvm_done,
  input  logic [2*B-1:0]   mvm_result
);

  localparam int unsigned RW    = 2 * B;
  localparam int unsigned DEPTH = K * P;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CMAX  = (TIMEOUT > RES_OFFSET + K) ? TIMEOUT : RES_OFFSET + K;
  localparam int unsigned CW    = $clog2(CMAX + 1);

  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_FILL      = ST_FILL;
  localparam logic [2:0] S_ARM       = ST_ARM;
  localparam logic [2:0] S_BURST     = ST_BURST;
  localparam logic [2:0] S_GAP       = ST_GAP;
  localparam logic [2:0] S_WAIT_DONE = ST_WAIT_DONE;
  localparam logic [2:0] S_CAPTURE   = ST_CAPTURE;
  localparam logic [2:0] S_DRAIN     = ST_DRAIN;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;      // fill write index / burst word index
  logic [AW-1:0] last_q, last_d;    // index of the final word of this load
  logic          mat_q, mat_d;      // current load targets the matrix
  logic [CW-1:0] cnt_q, cnt_d;      // gap / timeout / capture cycle counter
  logic [SW-1:0] ridx_q, ridx_d;    // drain slot index
  logic          err_q, err_d;
  logic [RW-1:0] res_data_q, res_data_d;
  logic          ld_mat_q, ld_mat_d;
  logic          ld_vec_q, ld_vec_d;
  logic          start_q, start_d;
  logic          cmd_ready_q, in_ready_q, busy_q, res_valid_q;

  logic          cmd_fire, in_fire, pop;
  logic          wr_en, rd_en, cap_en;
  logic [AW-1:0] rd_addr;
  logic [B-1:0]  rd_data;
  logic [RW-1:0] slots [K];

  assign cmd_fire = host.cmd_valid & cmd_ready_q;
  assign in_fire  = host.in_valid & in_ready_q;
  assign pop      = res_valid_q & host.res_ready;

  // Read latency of the buffer is covered by ARM; rd_data is zero whenever no
  // read was issued the cycle before, so it drives mvm_data directly.
  mvm_host_driver_mem #(
    .W     (B),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (idx_q),
    .wr_data (host.in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    mat_d      = mat_q;
    cnt_d      = cnt_q;
    ridx_d     = ridx_q;
    err_d      = err_q;
    res_data_d = res_data_q;
    ld_mat_d   = 1'b0;
    ld_vec_d   = 1'b0;
    start_d    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    cap_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          err_d = 1'b0;
          idx_d = '0;
          cnt_d = '0;
          case (host.cmd_op)
            OP_LOAD_MATRIX: begin
              state_d = S_FILL;
              mat_d   = 1'b1;
              last_d  = AW'(DEPTH - 1);
            end
            OP_LOAD_VECTOR: begin
              state_d = S_FILL;
              mat_d   = 1'b0;
              last_d  = AW'(K - 1);
            end
            OP_RUN: begin
              state_d = S_WAIT_DONE;
              start_d = 1'b1;
            end
            default: ;  // reserved op: consumed, no effect
          endcase
        end
      end

      S_FILL: begin
        wr_en = in_fire;
        if (in_fire) begin
          if (idx_q == last_q) begin
            state_d  = S_ARM;
            idx_d    = '0;
            ld_mat_d = mat_q;
            ld_vec_d = !mat_q;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end

      S_ARM: begin
        rd_en   = 1'b1;
        state_d = S_BURST;
      end

      // Each cycle shows word idx while prefetching idx+1.
      S_BURST: begin
        if (idx_q == last_q) begin
          state_d = S_GAP;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          rd_en   = 1'b1;
          rd_addr = idx_q + AW'(1);
          idx_d   = idx_q + AW'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (mvm_done) begin
          state_d = S_CAPTURE;
          cnt_d   = CW'(1);  // cnt now counts cycles since the done pulse
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_CAPTURE: begin
        cap_en = 1'b1;
        if (cnt_q == CW'(RES_OFFSET + K - 1)) begin
          state_d    = S_DRAIN;
          cnt_d      = '0;
          ridx_d     = '0;
          res_data_d = (K == 1) ? mvm_result : slots[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DRAIN: begin
        if (pop) begin
          if (ridx_q == SW'(K - 1)) begin
            state_d = S_IDLE;
            ridx_d  = '0;
          end else begin
            ridx_d     = ridx_q + SW'(1);
            res_data_d = slots[ridx_q + SW'(1)];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      mat_q       <= 1'b0;
      cnt_q       <= '0;
      ridx_q      <= '0;
      err_q       <= 1'b0;
      res_data_q  <= '0;
      ld_mat_q    <= 1'b0;
      ld_vec_q    <= 1'b0;
      start_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      mat_q       <= mat_d;
      cnt_q       <= cnt_d;
      ridx_q      <= ridx_d;
      err_q       <= err_d;
      res_data_q  <= res_data_d;
      ld_mat_q    <= ld_mat_d;
      ld_vec_q    <= ld_vec_d;
      start_q     <= start_d;
      cmd_ready_q <= (state_d == S_IDLE);
      in_ready_q  <= (state_d == S_FILL);
      busy_q      <= (state_d != S_IDLE);
      res_valid_q <= (state_d == S_DRAIN);
    end
  end

  // Result slots: slot s takes mvm_result RES_OFFSET+s cycles after done.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int unsigned s = 0; s < K; s++) begin
        if (cnt_q == CW'(RES_OFFSET + s)) begin
          slots[s] <= mvm_result;
        end
      end
    end
  end

  assign host.cmd_ready   = cmd_ready_q;
  assign host.in_ready    = in_ready_q;
  assign host.res_valid   = res_valid_q;
  assign host.res_data    = res_data_q;
  assign host.busy        = busy_q;
  assign host.timeout_err = err_q;
  assign mvm_loadMatrix   = ld_mat_q;
  assign mvm_loadVector   = ld_vec_q;
  assign mvm_start        = start_q;
  assign mvm_data         = rd_data;

endmodule

// File: tb/tb_mvm_host_driver.sv
// Directed bench for mvm_host_driver (K=8, P=8, B=20, RES_OFFSET=2, TIMEOUT=1023).
module tb_mvm_host_driver;
  import mvm_pkg::*;

  localparam int unsigned K  = 8;
  localparam int unsigned P  = 8;
  localparam int unsigned B  = 20;
  localparam int unsigned RW = 2 * B;
  localparam int unsigned RO = 2;
  localparam int unsigned TO = 1023;
  localparam logic [RW-1:0] JUNK = 40'hBAD00_BAD00;

  logic          clk = 1'b0;
  logic          reset;
  logic          mvm_loadMatrix, mvm_loadVector, mvm_start;
  logic [B-1:0]  mvm_data;
  logic          mvm_done;
  logic [RW-1:0] mvm_result;

  int tests = 0;
  int fails = 0;

  mvm_host_driver_if #(.B(B)) hif ();

  mvm_host_driver #(
    .K(K), .P(P), .B(B), .RES_OFFSET(RO), .TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .host           (hif),
    .mvm_loadMatrix (mvm_loadMatrix),
    .mvm_loadVector (mvm_loadVector),
    .mvm_start      (mvm_start),
    .mvm_data       (mvm_data),
    .mvm_done       (mvm_done),
    .mvm_result     (mvm_result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: called and returning at a negedge.
  task automatic send_cmd(input cmd_op_e op, output bit ok);
    int t = 0;
    hif.cmd_valid = 1'b1;
    hif.cmd_op    = op;
    while (!hif.cmd_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    ok = hif.cmd_ready;
    @(posedge clk);
    @(negedge clk);
    hif.cmd_valid = 1'b0;
  endtask

  task automatic push_word(input logic [B-1:0] w, output bit ok);
    int t = 0;
    hif.in_valid = 1'b1;
    hif.in_data  = w;
    while (!hif.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = hif.in_ready;
    @(posedge clk);
    @(negedge clk);
    hif.in_valid = 1'b0;
  endtask

  // Done pulse now, results on cycles done+RO .. done+RO+K-1; returns at done+RO+K.
  task automatic mvm_respond(input logic [RW-1:0] vals [K]);
    mvm_done   = 1'b1;
    mvm_result = JUNK;
    @(negedge clk);
    mvm_done = 1'b0;
    repeat (RO - 1) @(negedge clk);
    for (int i = 0; i < K; i++) begin
      mvm_result = vals[i];
      @(negedge clk);
    end
    mvm_result = JUNK;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({hif.cmd_ready, hif.in_ready, hif.busy, hif.timeout_err, hif.res_valid,
         mvm_loadMatrix, mvm_loadVector, mvm_start} !== 8'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00000000", {hif.cmd_ready, hif.in_ready,
               hif.busy, hif.timeout_err, hif.res_valid, mvm_loadMatrix, mvm_loadVector, mvm_start});
    end
    tests++;
    if (mvm_data !== '0) begin
      fails++;
      $display("FAIL reset_mvm_data: got %h want 0", mvm_data);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (hif.cmd_ready !== 1'b1 || hif.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_ready: cmd_ready %b busy %b want 1 0", hif.cmd_ready, hif.busy);
    end
  endtask

  task automatic test_load_matrix;
    bit ok, ok_all;
    hif.in_valid = 1'b1;
    hif.in_data  = 20'h5A5A5;
    @(negedge clk);
    @(negedge clk);
    hif.in_valid = 1'b0;
    tests++;
    if (hif.in_ready !== 1'b0 || hif.busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_in_ignored: in_ready %b busy %b want 0 0", hif.in_ready, hif.busy);
    end
    send_cmd(OP_LOAD_MATRIX, ok_all);
    tests++;
    if (hif.in_ready !== 1'b1 || hif.busy !== 1'b1 || hif.cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL mat_fill_flags: in_ready %b busy %b cmd_ready %b want 1 1 0",
               hif.in_ready, hif.busy, hif.cmd_ready);
    end
    for (int i = 1; i <= K * P; i++) begin
      push_word(B'(i), ok);
      ok_all &= ok;
    end
    tests++;
    if (!ok_all) begin
      fails++;
      $display("FAIL mat_handshake: got stalled want accepted");
    end
    tests++;
    if ({mvm_loadMatrix, mvm_loadVector, mvm_start} !== 3'b100 || mvm_data !== '0) begin
      fails++;
      $display("FAIL mat_arm: strobes %b data %h want 100 0",
               {mvm_loadMatrix, mvm_loadVector, mvm_start}, mvm_data);
    end
    for (int i = 0; i < K * P; i++) begin
      @(negedge clk);
      tests++;
      if (mvm_data !== B'(i + 1) || {mvm_loadMatrix, mvm_loadVector, mvm_start} !== 3'b000) begin
        fails++;
        $display("FAIL mat_burst[%0d]: data %h strobes %b want %h 000", i, mvm_data,
                 {mvm_loadMatrix, mvm_loadVector, mvm_start}, B'(i + 1));
      end
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      tests++;
      if (mvm_data !== '0 || {mvm_loadMatrix, mvm_loadVector, mvm_start} !== 3'b000 ||
          hif.busy !== 1'b1 || hif.cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL mat_gap[%0d]: data %h strobes %b busy %b ready %b want 0 000 1 0", g,
                 mvm_data, {mvm_loadMatrix, mvm_loadVector, mvm_start}, hif.busy, hif.cmd_ready);
      end
    end
    @(negedge clk);
    tests++;
    if (hif.cmd_ready !== 1'b1 || hif.busy !== 1'b0) begin
      fails++;
      $display("FAIL mat_done_idle: cmd_ready %b busy %b want 1 0", hif.cmd_ready, hif.busy);
    end
  endtask

  task automatic test_vector_toggle;
    bit ok, ok_all;
    send_cmd(OP_LOAD_VECTOR, ok_all);
    for (int i = 0; i < K; i++) begin
      push_word(20'hA0000 | B'(i), ok);
      ok_all &= ok;
      if (i < K - 1) @(negedge clk);
    end
    tests++;
    if (!ok_all) begin
      fails++;
      $display("FAIL vec_handshake: got stalled want accepted");
    end
    tests++;
    if ({mvm_loadMatrix, mvm_loadVector, mvm_start} !== 3'b010 || mvm_data !== '0) begin
      fails++;
      $display("FAIL vec_arm: strobes %b data %h want 010 0",
               {mvm_loadMatrix, mvm_loadVector, mvm_start}, mvm_data);
    end
    for (int i = 0; i < K; i++) begin
      @(negedge clk);
      tests++;
      if (mvm_data !== (20'hA0000 | B'(i)) || {mvm_loadMatrix, mvm_loadVector, mvm_start} !== 3'b000) begin
        fails++;
        $display("FAIL vec_burst[%0d]: data %h want %h", i, mvm_data, 20'hA0000 | B'(i));
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (hif.cmd_ready !== 1'b1 || mvm_data !== '0) begin
      fails++;
      $display("FAIL vec_done_idle: cmd_ready %b data %h want 1 0", hif.cmd_ready, mvm_data);
    end
  endtask

  task automatic test_run_backpressure;
    bit ok;
    logic [RW-1:0] vals [K];
    for (int i = 0; i < K; i++) vals[i] = RW'(i * 3);
    mvm_done = 1'b1;
    @(negedge clk);
    mvm_done = 1'b0;
    @(negedge clk);
    tests++;
    if (hif.busy !== 1'b0 || hif.cmd_ready !== 1'b1 || hif.res_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_done_ignored: busy %b ready %b res_valid %b want 0 1 0",
               hif.busy, hif.cmd_ready, hif.res_valid);
    end
    hif.res_ready = 1'b0;
    send_cmd(OP_RUN, ok);
    tests++;
    if (!ok || {mvm_loadMatrix, mvm_loadVector, mvm_start} !== 3'b001 || hif.busy !== 1'b1) begin
      fails++;
      $display("FAIL run_start: strobes %b busy %b want 001 1",
               {mvm_loadMatrix, mvm_loadVector, mvm_start}, hif.busy);
    end
    @(negedge clk);
    tests++;
    if (mvm_start !== 1'b0) begin
      fails++;
      $display("FAIL run_start_width: start %b want 0", mvm_start);
    end
    mvm_respond(vals);
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (hif.res_valid !== 1'b1 || hif.res_data !== vals[0]) begin
        fails++;
        $display("FAIL run_hold[%0d]: valid %b data %h want 1 %h", c, hif.res_valid,
                 hif.res_data, vals[0]);
      end
      @(negedge clk);
    end
    hif.res_ready = 1'b1;
    for (int i = 0; i < K; i++) begin
      tests++;
      if (hif.res_valid !== 1'b1 || hif.res_data !== vals[i]) begin
        fails++;
        $display("FAIL run_result[%0d]: valid %b data %h want 1 %h", i, hif.res_valid,
                 hif.res_data, vals[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (hif.res_valid !== 1'b0 || hif.cmd_ready !== 1'b1 || hif.busy !== 1'b0) begin
      fails++;
      $display("FAIL run_end: valid %b ready %b busy %b want 0 1 0", hif.res_valid,
               hif.cmd_ready, hif.busy);
    end
    hif.res_ready = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok, ok_all;
    int t;
    send_cmd(OP_RUN, ok_all);
    repeat (TO - 1) @(negedge clk);
    tests++;
    if (hif.busy !== 1'b1 || hif.timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL to_last_wait: busy %b err %b want 1 0", hif.busy, hif.timeout_err);
    end
    @(negedge clk);
    tests++;
    if (hif.busy !== 1'b0 || hif.timeout_err !== 1'b1 || hif.cmd_ready !== 1'b1 ||
        hif.res_valid !== 1'b0) begin
      fails++;
      $display("FAIL to_expired: busy %b err %b ready %b valid %b want 0 1 1 0",
               hif.busy, hif.timeout_err, hif.cmd_ready, hif.res_valid);
    end
    send_cmd(OP_LOAD_VECTOR, ok);
    ok_all &= ok;
    tests++;
    if (hif.timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL to_clear: err %b want 0", hif.timeout_err);
    end
    for (int i = 0; i < K; i++) begin
      push_word(B'(20'h00100 + i), ok);
      ok_all &= ok;
    end
    t = 0;
    while (!hif.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (!ok_all || hif.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL to_reload: ready %b handshakes %b want 1 1", hif.cmd_ready, ok_all);
    end
  endtask

  task automatic test_reset_mid_burst;
    bit ok, ok_all;
    send_cmd(OP_LOAD_MATRIX, ok_all);
    for (int i = 0; i < K * P; i++) begin
      push_word(B'(20'h03000 + i), ok);
      ok_all &= ok;
    end
    repeat (31) @(negedge clk);
    tests++;
    if (!ok_all || mvm_data !== B'(20'h03000 + 30)) begin
      fails++;
      $display("FAIL rst_burst_word30: data %h want %h", mvm_data, B'(20'h03000 + 30));
    end
    reset = 1'b0;
    #1;
    tests++;
    if (mvm_data !== '0 || {mvm_loadMatrix, mvm_loadVector, mvm_start} !== 3'b000 ||
        hif.busy !== 1'b0 || hif.cmd_ready !== 1'b0 || hif.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_abort: data %h strobes %b busy %b ready %b in_ready %b want 0 000 0 0 0",
               mvm_data, {mvm_loadMatrix, mvm_loadVector, mvm_start}, hif.busy,
               hif.cmd_ready, hif.in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (hif.cmd_ready !== 1'b1 || hif.busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_release_ready: ready %b busy %b want 1 0", hif.cmd_ready, hif.busy);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (mvm_data !== '0 || {mvm_loadMatrix, mvm_loadVector, mvm_start} !== 3'b000) begin
        fails++;
        $display("FAIL rst_quiet[%0d]: data %h strobes %b want 0 000", c, mvm_data,
                 {mvm_loadMatrix, mvm_loadVector, mvm_start});
      end
    end
  endtask

  task automatic test_reserved_then_run;
    bit ok, ok_all;
    logic [RW-1:0] vals [K];
    for (int i = 0; i < K; i++) vals[i] = -(RW'(i * 7 + 1));
    send_cmd(OP_RESERVED, ok_all);
    for (int c = 0; c < 2; c++) begin
      tests++;
      if ({mvm_loadMatrix, mvm_loadVector, mvm_start} !== 3'b000 || hif.busy !== 1'b0 ||
          hif.cmd_ready !== 1'b1) begin
        fails++;
        $display("FAIL reserved_drop[%0d]: strobes %b busy %b ready %b want 000 0 1", c,
                 {mvm_loadMatrix, mvm_loadVector, mvm_start}, hif.busy, hif.cmd_ready);
      end
      @(negedge clk);
    end
    send_cmd(OP_LOAD_VECTOR, ok);
    ok_all &= ok;
    hif.cmd_valid = 1'b1;
    hif.cmd_op    = OP_RUN;
    for (int i = 0; i < K; i++) begin
      push_word(B'(20'h07000 + i), ok);
      ok_all &= ok;
    end
    // n=0 is ARM, 1..8 burst, 9..10 gap, 11 back in IDLE.
    for (int n = 0; n < 12; n++) begin
      tests++;
      if (mvm_start !== 1'b0 || hif.cmd_ready !== (n == 11) ||
          (n >= 1 && n <= 8 && mvm_data !== B'(20'h07000 + n - 1))) begin
        fails++;
        $display("FAIL busy_run_held[%0d]: start %b ready %b data %h", n, mvm_start,
                 hif.cmd_ready, mvm_data);
      end
      @(negedge clk);
    end
    hif.cmd_valid = 1'b0;
    tests++;
    if (!ok_all || mvm_start !== 1'b1) begin
      fails++;
      $display("FAIL busy_run_accept: start %b want 1", mvm_start);
    end
    hif.res_ready = 1'b1;
    mvm_respond(vals);
    for (int i = 0; i < K; i++) begin
      tests++;
      if (hif.res_valid !== 1'b1 || hif.res_data !== vals[i]) begin
        fails++;
        $display("FAIL neg_result[%0d]: valid %b data %h want 1 %h", i, hif.res_valid,
                 hif.res_data, vals[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (hif.res_valid !== 1'b0 || hif.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL neg_end: valid %b ready %b want 0 1", hif.res_valid, hif.cmd_ready);
    end
    hif.res_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    hif.cmd_valid = 1'b0;
    hif.cmd_op    = OP_LOAD_MATRIX;
    hif.in_valid  = 1'b0;
    hif.in_data   = '0;
    hif.res_ready = 1'b0;
    mvm_done      = 1'b0;
    mvm_result    = JUNK;

    test_reset();
    test_load_matrix();
    test_vector_toggle();
    test_run_backpressure();
    test_timeout();
    test_reset_mid_burst();
    test_reserved_then_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mvm_host_driver.md
MVM_HOST_DRIVER -- requirements
Module: mvm_host_driver

Interface
REQ-001 Parameter K, default 8: MVM output rows, and the number of vector words.
REQ-002 Parameter P, default 8: MVM column count; one matrix load carries K*P words.
REQ-003 Parameter B, default 20: operand width.
REQ-004 Parameter RES_OFFSET, default 2: cycles from the mvm_done pulse to the first valid mvm_result word.
REQ-005 Parameter TIMEOUT, default 1023: maximum cycles spent in WAIT_DONE.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-008 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-009 cmd_op  in  2  0=LOAD_MATRIX, 1=LOAD_VECTOR, 2=RUN, 3=reserved.
REQ-010 in_valid / in_ready / in_data  in / out / in  1 / 1 / B  operand word stream.
REQ-011 res_valid / res_ready / res_data  out / in / out  1 / 1 / 2B  result stream.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 timeout_err  out  1  sticky flag for a RUN timeout.
REQ-014 mvm_loadMatrix, mvm_loadVector, mvm_start  out  1 each  strobes to the MVM.
REQ-015 mvm_data  out  B  MVM data_in.
REQ-016 mvm_done  in  1  MVM completion pulse.
REQ-017 mvm_result  in  2B  MVM data_out.

Function
REQ-018 States SHALL be: IDLE, FILL, ARM, BURST, GAP, WAIT_DONE, CAPTURE, DRAIN.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-020 LOAD_MATRIX SHALL go to FILL with N=K*P; LOAD_VECTOR SHALL go to FILL with N=K.
REQ-021 In FILL, in_ready=1; each in handshake writes the staging buffer at index 0..N-1; after the N-th word, go to ARM.
REQ-022 in_valid outside FILL SHALL be ignored (in_ready=0).
REQ-023 ARM SHALL last exactly 1 cycle: assert the matching load strobe, mvm_data=0, and issue buffer read of index 0.
REQ-024 BURST SHALL drive buffer words 0..N-1 on mvm_data on N consecutive cycles, starting the cycle after ARM, with no gaps.
REQ-025 GAP SHALL hold all strobes low and mvm_data=0 for 2 cycles, then return to IDLE.
REQ-026 RUN SHALL assert mvm_start for exactly 1 cycle, then enter WAIT_DONE with the timeout counter cleared.
REQ-027 On mvm_done in WAIT_DONE, go to CAPTURE.
REQ-028 CAPTURE SHALL sample mvm_result on cycles done+RES_OFFSET .. done+RES_OFFSET+K-1 into result slots 0..K-1.
REQ-029 After CAPTURE, go to DRAIN.
REQ-030 In DRAIN, res_valid=1 and res_data=slot[i]; i advances on res_valid & res_ready; after slot K-1 pops, go to IDLE.
REQ-031 res_data SHALL remain stable while res_valid & !res_ready.
REQ-032 If the WAIT_DONE counter reaches TIMEOUT without mvm_done, go to IDLE with no results and set timeout_err.
REQ-033 timeout_err SHALL clear on the next accepted command.
REQ-034 A reserved cmd_op SHALL be accepted and dropped; no strobes, state stays IDLE.
REQ-035 mvm_done outside WAIT_DONE SHALL be ignored.
REQ-036 At most one of the three strobes SHALL be high in any cycle.
REQ-037 mvm_data SHALL be 0 outside BURST.
REQ-038 Results SHALL be passed through unmodified (2B bits, signed); no arithmetic is done on them.

Reset
REQ-039 While reset=0: state=IDLE, all strobes=0, mvm_data=0, res_valid=0, cmd_ready=0, in_ready=0, busy=0, timeout_err=0, all counters=0.
REQ-040 Buffer contents after reset are don't-care.
REQ-041 Reset asserted mid-BURST or mid-DRAIN SHALL abort at once; no partial strobe or result SHALL be emitted after release.
REQ-042 cmd_ready SHALL rise on the first clk edge after reset deasserts.

Structure
REQ-043 Package mvm_pkg SHALL hold: the cmd_op enum, the state enum, and default K/P/B constants.
REQ-044 The staging buffer SHALL be one instance of the existing memory module: width B, depth K*P, with its 1-cycle read latency absorbed by ARM.
REQ-045 Result slots SHALL be a K x 2B register array local to the block.

Verification
REQ-046 LOAD_MATRIX, feed words 1..64 with no stalls -> mvm_loadMatrix for 1 cycle, then mvm_data=1..64 on 64 consecutive cycles, then 2 GAP cycles, then cmd_ready=1.
REQ-047 LOAD_VECTOR, feed words with in_valid toggling every other cycle -> BURST still 8 gapless words 0..7 in order.
REQ-048 RUN with a model MVM returning y=i*3 for i=0..7 at RES_OFFSET=2, and res_ready held low for 5 cycles -> res_data stable, then 0,3,..,21 delivered in order.
REQ-049 RUN with mvm_done never asserted -> timeout_err=1 after 1023 WAIT_DONE cycles, state IDLE; next LOAD_VECTOR clears timeout_err.
REQ-050 Reset pulled low at BURST word 30 -> all strobes and mvm_data at 0 immediately; after release, cmd_ready=1 on the first edge.
REQ-051 cmd_op=3, then cmd_op=2 presented while busy -> no strobes for op 3; op 2 not accepted until IDLE.
